rasterize_line_bresenham: RTL and testbench
===========================================

// Module: rasterize_line_bresenham
// PURPOSE
// - Screen-space line rasterizer: accepts one integer endpoint pair per line, emits one pixel coordinate per cycle (Bresenham, all octants).
// - Sits downstream of the Z-plane clip / projection stage; its pixel stream feeds the framebuffer write port.
// - valid/ready handshake on both sides; one line in flight at a time.
// PARAMETERS
// - COORD_W   16   width of signed two's-complement screen coordinates
// - SCREEN_W  640  horizontal extent, used only with SCREEN_CLIP_EN
// - SCREEN_H  480  vertical extent, used only with SCREEN_CLIP_EN
// PORTS
// - CLOCK_50   in   1        single clock, all logic posedge
// - reset_n    in   1        asynchronous active-low reset
// - in_valid   in   1        endpoint pair valid
// - in_ready   out  1        high only in IDLE
// - x0,y0      in   COORD_W  start point, signed
// - x1,y1      in   COORD_W  end point, signed
// - pix_valid  out  1        px/py valid
// - pix_ready  in   1        downstream accepts pixel
// - px,py      out  COORD_W  pixel coordinate, signed
// - pix_last   out  1        qualifies final Bresenham pixel (x1,y1)
// - line_done  out  1        one-cycle pulse when the line completes
// - busy       out  1        high in any state but IDLE
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low.
// - Reset: state=IDLE; in_ready=1; pix_valid, pix_last, line_done, busy=0; px, py, internal err/dx/dy=0.
// - Reset mid-line aborts; the line is discarded with no pix_last and no line_done.
// - FSM: IDLE -(in_valid&in_ready)-> SETUP -> STEP -(final pixel accepted)-> IDLE.
// - SETUP (1 cycle): dx=|x1-x0|, dy=-|y1-y0|, sx=(x0<x1)?+1:-1, sy=(y0<y1)?+1:-1, err=dx+dy.
//   - Internal width COORD_W+2 signed, with no overflow for any input pair.
//   - Current point = (x0,y0).
// - Latency: pair accepted in cycle N; first pix_valid in cycle N+2.
// - STEP: pix_valid=1 with px,py = current point.
//   - On pix_valid&pix_ready: if current==(x1,y1), emit pix_last with this pixel; line_done pulses the next cycle with state=IDLE.
//   - Otherwise e2=2*err. If e2>=dy: err+=dy, x+=sx. If e2<=dx: err+=dx, y+=sy. Both updates use the pre-update err.
// - Throughput: 1 pixel/cycle while pix_ready=1. Pixel count = max(dx,|dy|)+1.
// - Backpressure: while pix_valid&!pix_ready, px, py and pix_last hold stable and the stepper freezes.
// - Degenerate line (x0==x1 & y0==y1): exactly one pixel, with pix_last=1.
// - in_ready=0 from SETUP until back in IDLE, so new pairs are not sampled. in_ready returns high in the line_done cycle.
// CONFIGURATION
// - SCREEN_CLIP_EN defined:
//   - Points with px<0, px>=SCREEN_W, py<0 or py>=SCREEN_H are stepped internally but not presented (pix_valid=0 for that cycle, 1 step/cycle).
//   - pix_last is asserted only if (x1,y1) is on-screen. line_done always pulses.
// - SCREEN_CLIP_EN undefined: every point is presented; SCREEN_W and SCREEN_H are ignored.
// STRUCTURE
// - Package rasterize_pkg:
//   - COORD_W default
//   - typedef coord_t (signed [COORD_W-1:0])
//   - typedef err_t (signed [COORD_W+1:0])
//   - enum line_state_t {IDLE, SETUP, STEP}
// - Sub-module bresenham_step: combinational next (x,y,err) from (x,y,err,dx,dy,sx,sy). Instantiated once; holds no state.
// - Top: FSM, endpoint/delta registers, output registers, handshake.
// TESTING
// - Horizontal (0,0)->(4,0), pix_ready=1: pixels x=0..4, y=0; pix_last on (4,0); first pixel at N+2; line_done the next cycle.
// - Steep negative (2,3)->(0,-2): 6 pixels (2,3)(2,2)(1,1)(1,0)(0,-1)(0,-2); match a software Bresenham model.
// - Degenerate (7,7)->(7,7): single pixel with pix_last=1; in_ready=0 during SETUP, then 1.
// - Backpressure on (0,0)->(3,3): pix_ready toggles 1,0,0,1,... ; px/py stable while stalled; 4 pixels total with no duplicates.
// - Reset mid-line: assert reset_n=0 on the 3rd pixel of (0,0)->(10,5). Outputs clear immediately; the next pair rasterizes correctly.
// - With SCREEN_CLIP_EN, (-2,0)->(2,0): only (0,0)(1,0)(2,0) presented, pix_last on (2,0). For (638,0)->(642,0): 2 pixels, no pix_last, line_done pulses.

Source files
------------

// File: rtl/rasterize_line_bresenham_pkg.sv
// Shared types for the Bresenham line rasterizer: coordinate/error widths and line FSM states.
package rasterize_pkg;

  localparam int COORD_W = 16;

  typedef logic signed [COORD_W-1:0] coord_t;
  // Two extra bits keep dx, dy, err and 2*err free of overflow for any endpoint pair.
  typedef logic signed [COORD_W+1:0] err_t;

  typedef enum logic [1:0] {IDLE, SETUP, STEP} line_state_t;

  function automatic err_t absDiff(input coord_t a, input coord_t b);
    err_t d;
    d = err_t'(b) - err_t'(a);
    return (d < 0) ? -d : d;
  endfunction

endpackage

// File: rtl/rasterize_line_bresenham_if.sv
// Endpoint-in / pixel-out handshake bundle of the line rasterizer.
interface rasterize_line_bresenham_if;
  import rasterize_pkg::*;

  logic   in_valid;
  logic   in_ready;
  coord_t x0, y0, x1, y1;
  logic   pix_valid;
  logic   pix_ready;
  coord_t px, py;
  logic   pix_last;
  logic   line_done;
  logic   busy;

  modport slave (
    input  in_valid, x0, y0, x1, y1, pix_ready,
    output in_ready, pix_valid, px, py, pix_last, line_done, busy
  );

  modport master (
    output in_valid, x0, y0, x1, y1, pix_ready,
    input  in_ready, pix_valid, px, py, pix_last, line_done, busy
  );

endinterface

// File: rtl/rasterize_line_bresenham_step.sv
// Combinational Bresenham step: next point and error term from the current ones.
module bresenham_step
  import rasterize_pkg::*;
(
  input  coord_t x,
  input  coord_t y,
  input  err_t   err,
  input  err_t   dx,
  input  err_t   dy,
  input  logic   sxNeg,
  input  logic   syNeg,
  output coord_t xNext,
  output coord_t yNext,
  output err_t   errNext
);

  err_t e2;

  // Both decisions compare against the pre-update error.
  always_comb begin
    e2      = err <<< 1;
    xNext   = x;
    yNext   = y;
    errNext = err;
    if (e2 >= dy) begin
      errNext = errNext + dy;
      xNext   = sxNeg ? x - coord_t'(1) : x + coord_t'(1);
    end
    if (e2 <= dx) begin
      errNext = errNext + dx;
      yNext   = syNeg ? y - coord_t'(1) : y + coord_t'(1);
    end
  end

endmodule

// File: rtl/rasterize_line_bresenham.sv
// Screen-space Bresenham line rasterizer, one pixel per cycle, all octants.
// Optional SCREEN_CLIP_EN suppresses presentation of off-screen pixels.
module rasterize_line_bresenham
  import rasterize_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input logic                        CLOCK_50,
  input logic                        reset_n,
  rasterize_line_bresenham_if.slave  bus
);

  if (SCREEN_W < 1 || SCREEN_H < 1 ||
      SCREEN_W > 2**(COORD_W-1) || SCREEN_H > 2**(COORD_W-1)) begin : g_badExtent
    $error("screen extents do not fit coord_t");
  end

  line_state_t state, stateNext;
  coord_t      xCur, yCur, xEnd, yEnd;
  coord_t      xNext, yNext;
  err_t        err, errNext, dx, dy;
  logic        sxNeg, syNeg;
  logic        atEnd, onScreen, advance, lineDoneR;

  assign atEnd = (xCur == xEnd) && (yCur == yEnd);

`ifdef SCREEN_CLIP_EN
  localparam coord_t SCREEN_W_C = coord_t'(SCREEN_W);
  localparam coord_t SCREEN_H_C = coord_t'(SCREEN_H);
  assign onScreen = !xCur[COORD_W-1] && (xCur < SCREEN_W_C) &&
                    !yCur[COORD_W-1] && (yCur < SCREEN_H_C);
`else
  assign onScreen = 1'b1;
`endif

  // Off-screen points never wait for the sink, so the stepper keeps moving.
  assign advance = (state == STEP) && (bus.pix_ready || !onScreen);

  bresenham_step u_step (
    .x      (xCur),
    .y      (yCur),
    .err    (err),
    .dx     (dx),
    .dy     (dy),
    .sxNeg  (sxNeg),
    .syNeg  (syNeg),
    .xNext  (xNext),
    .yNext  (yNext),
    .errNext(errNext)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (bus.in_valid) stateNext = SETUP;
      SETUP:   stateNext = STEP;
      STEP:    if (advance && atEnd) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      xCur      <= '0;
      yCur      <= '0;
      xEnd      <= '0;
      yEnd      <= '0;
      err       <= '0;
      dx        <= '0;
      dy        <= '0;
      sxNeg     <= 1'b0;
      syNeg     <= 1'b0;
      lineDoneR <= 1'b0;
    end else begin
      lineDoneR <= advance && atEnd;
      unique case (state)
        IDLE: if (bus.in_valid) begin
          xCur <= bus.x0;
          yCur <= bus.y0;
          xEnd <= bus.x1;
          yEnd <= bus.y1;
        end
        SETUP: begin
          dx    <= absDiff(xCur, xEnd);
          dy    <= -absDiff(yCur, yEnd);
          err   <= absDiff(xCur, xEnd) - absDiff(yCur, yEnd);
          sxNeg <= !(xCur < xEnd);
          syNeg <= !(yCur < yEnd);
        end
        STEP: if (advance && !atEnd) begin
          xCur <= xNext;
          yCur <= yNext;
          err  <= errNext;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.pix_valid = (state == STEP) && onScreen;
  assign bus.pix_last  = (state == STEP) && onScreen && atEnd;
  assign bus.px        = xCur;
  assign bus.py        = yCur;
  assign bus.line_done = lineDoneR;

endmodule

// File: tb/tb_rasterize_line_bresenham.sv
// Directed bench for rasterize_line_bresenham; expected pixel lists are hand-computed.
module tb_rasterize_line_bresenham;
  import rasterize_pkg::*;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;

  rasterize_line_bresenham_if bus();

  rasterize_line_bresenham #(.SCREEN_W(640), .SCREEN_H(480)) dut (
    .CLOCK_50(CLOCK_50),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int expX[$];
  int expY[$];
  bit expLast;
  bit bpPat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic checkVal(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic sendLine(input int ax0, input int ay0, input int ax1, input int ay1);
    @(negedge CLOCK_50);
    bus.x0       = coord_t'(ax0);
    bus.y0       = coord_t'(ay0);
    bus.x1       = coord_t'(ax1);
    bus.y1       = coord_t'(ay1);
    bus.in_valid = 1'b1;
    checkVal("accept_in_ready", int'(bus.in_ready), 1);
    @(posedge CLOCK_50);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collectLine(input string name, input bit bp, input bit checkLatency);
    int     idx = 0;
    int     cyc = 0;
    int     firstValid = -1;
    bit     done = 1'b0;
    bit     stalled = 1'b0;
    coord_t holdX = '0;
    coord_t holdY = '0;
    while (!done && cyc < 200) begin
      @(negedge CLOCK_50);
      cyc++;
      if (cyc == 1) begin
        checkVal($sformatf("%s_setup_in_ready", name), int'(bus.in_ready), 0);
        checkVal($sformatf("%s_setup_busy", name), int'(bus.busy), 1);
      end
      if (bus.pix_valid) begin
        if (firstValid < 0) firstValid = cyc;
        if (stalled) begin
          checkVal($sformatf("%s_hold_px", name), int'(bus.px), int'(holdX));
          checkVal($sformatf("%s_hold_py", name), int'(bus.py), int'(holdY));
        end
        if (idx < expX.size()) begin
          checkVal($sformatf("%s_px%0d", name, idx), int'(bus.px), expX[idx]);
          checkVal($sformatf("%s_py%0d", name, idx), int'(bus.py), expY[idx]);
          checkVal($sformatf("%s_last%0d", name, idx), int'(bus.pix_last),
                   int'((idx == expX.size() - 1) && expLast));
        end else begin
          checkVal($sformatf("%s_extra_pixel", name), idx, expX.size() - 1);
        end
        stalled = !bus.pix_ready;
        holdX   = bus.px;
        holdY   = bus.py;
        if (bus.pix_ready) idx++;
      end else begin
        stalled = 1'b0;
      end
      if (bus.line_done) begin
        done = 1'b1;
        checkVal($sformatf("%s_done_in_ready", name), int'(bus.in_ready), 1);
        checkVal($sformatf("%s_done_busy", name), int'(bus.busy), 0);
      end
      @(posedge CLOCK_50);
      #1;
      bus.pix_ready = bp ? bpPat[cyc % 4] : 1'b1;
    end
    bus.pix_ready = 1'b1;
    checkVal($sformatf("%s_line_done_seen", name), int'(done), 1);
    checkVal($sformatf("%s_pixel_count", name), idx, expX.size());
    if (checkLatency) checkVal($sformatf("%s_first_latency", name), firstValid, 2);
    @(negedge CLOCK_50);
    checkVal($sformatf("%s_done_pulse_width", name), int'(bus.line_done), 0);
  endtask

  initial begin
    int cyc;
    int idx;
    bus.in_valid  = 1'b0;
    bus.pix_ready = 1'b1;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;

    repeat (2) @(negedge CLOCK_50);
    checkVal("rst_in_ready", int'(bus.in_ready), 1);
    checkVal("rst_busy", int'(bus.busy), 0);
    checkVal("rst_pix_valid", int'(bus.pix_valid), 0);
    checkVal("rst_pix_last", int'(bus.pix_last), 0);
    checkVal("rst_line_done", int'(bus.line_done), 0);
    checkVal("rst_px", int'(bus.px), 0);
    checkVal("rst_py", int'(bus.py), 0);
    reset_n = 1'b1;

    // Horizontal line
    expX = '{0, 1, 2, 3, 4}; expY = '{0, 0, 0, 0, 0}; expLast = 1'b1;
    sendLine(0, 0, 4, 0);
    collectLine("horiz", 1'b0, 1'b1);

`ifndef SCREEN_CLIP_EN
    // Steep negative slope
    expX = '{2, 2, 1, 1, 0, 0}; expY = '{3, 2, 1, 0, -1, -2}; expLast = 1'b1;
    sendLine(2, 3, 0, -2);
    collectLine("steep", 1'b0, 1'b0);
`endif

    // Degenerate single-point line
    expX = '{7}; expY = '{7}; expLast = 1'b1;
    sendLine(7, 7, 7, 7);
    collectLine("degen", 1'b0, 1'b1);

    // Diagonal under backpressure
    expX = '{0, 1, 2, 3}; expY = '{0, 1, 2, 3}; expLast = 1'b1;
    sendLine(0, 0, 3, 3);
    collectLine("bp", 1'b1, 1'b0);

    // Reset while the third pixel of (0,0)->(10,5) is presented
    sendLine(0, 0, 10, 5);
    cyc = 0;
    idx = 0;
    while (cyc < 50) begin
      @(negedge CLOCK_50);
      cyc++;
      if (bus.pix_valid && idx == 2) break;
      if (bus.pix_valid && bus.pix_ready) idx++;
    end
    checkVal("abort_reached_third", idx, 2);
    checkVal("abort_third_px", int'(bus.px), 2);
    checkVal("abort_third_py", int'(bus.py), 1);
    reset_n = 1'b0;
    #1;
    checkVal("abort_pix_valid", int'(bus.pix_valid), 0);
    checkVal("abort_pix_last", int'(bus.pix_last), 0);
    checkVal("abort_busy", int'(bus.busy), 0);
    checkVal("abort_in_ready", int'(bus.in_ready), 1);
    checkVal("abort_px", int'(bus.px), 0);
    checkVal("abort_py", int'(bus.py), 0);
    repeat (2) begin
      @(negedge CLOCK_50);
      checkVal("abort_no_line_done", int'(bus.line_done), 0);
    end
    reset_n = 1'b1;

    expX = '{5, 4, 3, 2}; expY = '{1, 2, 2, 3}; expLast = 1'b1;
    sendLine(5, 1, 2, 3);
    collectLine("after_rst", 1'b0, 1'b1);

`ifdef SCREEN_CLIP_EN
    expX = '{0, 1, 2}; expY = '{0, 0, 0}; expLast = 1'b1;
    sendLine(-2, 0, 2, 0);
    collectLine("clip_left", 1'b0, 1'b0);

    expX = '{638, 639}; expY = '{0, 0}; expLast = 1'b0;
    sendLine(638, 0, 642, 0);
    collectLine("clip_right", 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
